// File: rtl/cnn_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : cnn_frame_sequencer_if
// Purpose  : Bundles the command, source pixel, conv pipeline, DNN result and
//            status signals of the CNN frame sequencer.
//            master : environment side (drives command/source/result inputs)
//            slave  : sequencer side (drives pipeline/result/status outputs)
// Signals  : start, num_frames                 - run command
//            src_valid, src_data, src_ready    - pixel source handshake
//            pipe_valid, pipe_data, pipe_ready - conv pipeline handshake
//            pipe_res                          - pipeline clear pulse
//            res_valid, res_data, res_done     - DNN result interface
//            out_valid, out_data, out_frame    - captured result
//            busy, done, timeout_err           - status
// Revision : 1.0 - initial release
// ============================================================================
interface cnn_frame_sequencer_if #(
    parameter int BitSize    = 32,
    parameter int NumOutputs = 2
);
    logic                           start;
    logic [7:0]                     num_frames;
    logic                           src_valid;
    logic [BitSize-1:0]             src_data;
    logic                           src_ready;
    logic                           pipe_ready;
    logic                           pipe_valid;
    logic [BitSize-1:0]             pipe_data;
    logic                           pipe_res;
    logic                           res_valid;
    logic [NumOutputs*BitSize-1:0]  res_data;
    logic                           res_done;
    logic                           out_valid;
    logic [NumOutputs*BitSize-1:0]  out_data;
    logic [7:0]                     out_frame;
    logic                           busy;
    logic                           done;
    logic                           timeout_err;

    modport master (
        output start, num_frames, src_valid, src_data, pipe_ready,
               res_valid, res_data, res_done,
        input  src_ready, pipe_valid, pipe_data, pipe_res,
               out_valid, out_data, out_frame, busy, done, timeout_err
    );

    modport slave (
        input  start, num_frames, src_valid, src_data, pipe_ready,
               res_valid, res_data, res_done,
        output src_ready, pipe_valid, pipe_data, pipe_res,
               out_valid, out_data, out_frame, busy, done, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/cnn_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cnn_frame_sequencer
// Purpose  : Frame-level controller in front of the conv/pooling + DNN chain.
//            Per frame: clears the pipeline, gates exactly ImageWidth^2 pixels
//            from the source into the pipeline, then waits (bounded by
//            DrainTimeout) for the DNN to finish, capturing its results.
// Ports    : clk   - clock
//            res_n - synchronous reset, active HIGH
//            bus   - cnn_frame_sequencer_if.slave (command, pixel, result,
//                    status signals)
// Revision : 1.0 - initial release
// ============================================================================
module cnn_frame_sequencer #(
    parameter int BitSize      = 32,
    parameter int ImageWidth   = 8,
    parameter int NumOutputs   = 2,
    parameter int ClearCycles  = 2,
    parameter int DrainTimeout = 1024
) (
    input wire                     clk,
    input wire                     res_n,
    cnn_frame_sequencer_if.slave   bus
);

    localparam int c_pixels = ImageWidth * ImageWidth;
    localparam int c_pix_w  = $clog2(c_pixels + 1);
    localparam int c_clr_w  = $clog2(ClearCycles + 1);
    localparam int c_wait_w = $clog2(DrainTimeout + 1);

    localparam logic [c_pix_w-1:0]  c_last_pix  = c_pix_w'(c_pixels - 1);
    localparam logic [c_clr_w-1:0]  c_last_clr  = c_clr_w'(ClearCycles - 1);
    localparam logic [c_wait_w-1:0] c_last_wait = c_wait_w'(DrainTimeout - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_NEXT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                         r_state;
    state_t                         w_next_state;

    logic [7:0]                     r_num_frames;
    logic [7:0]                     r_frame_idx;
    logic [c_pix_w-1:0]             r_pix_cnt;
    logic [c_clr_w-1:0]             r_clr_cnt;
    logic [c_wait_w-1:0]            r_wait_cnt;
    logic                           r_pipe_res;
    logic                           r_timeout_err;
    logic                           r_out_valid;
    logic [NumOutputs*BitSize-1:0]  r_out_data;
    logic [7:0]                     r_out_frame;

    logic                           w_stream;
    logic                           w_src_ready;
    logic                           w_transfer;
    logic                           w_timeout;
    logic [8:0]                     w_frame_inc;

    assign w_stream    = (r_state == S_STREAM);
    assign w_src_ready = w_stream & bus.pipe_ready;
    assign w_transfer  = w_src_ready & bus.src_valid;
    // Nine bits so that num_frames = 255 is reached without wrapping.
    assign w_frame_inc = {1'b0, r_frame_idx} + 9'd1;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.num_frames == 8'd0) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                if (r_clr_cnt == c_last_clr) begin
                    w_next_state = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_transfer && (r_pix_cnt == c_last_pix)) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // res_done wins over a coincident timeout.
                if (bus.res_done) begin
                    w_next_state = S_NEXT;
                end else if (r_wait_cnt == c_last_wait) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_NEXT;
                end
            end
            S_NEXT: begin
                if (w_frame_inc == {1'b0, r_num_frames}) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_CLEAR;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (res_n) begin
            r_state       <= S_IDLE;
            r_num_frames  <= 8'd0;
            r_frame_idx   <= 8'd0;
            r_pix_cnt     <= '0;
            r_clr_cnt     <= '0;
            r_wait_cnt    <= '0;
            r_pipe_res    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_frame   <= 8'd0;
        end else begin
            r_state     <= w_next_state;
            // Registered from next state so it is high exactly while in CLEAR.
            r_pipe_res  <= (w_next_state == S_CLEAR);
            r_out_valid <= 1'b0;

            if ((r_state == S_IDLE) && bus.start) begin
                r_num_frames  <= bus.num_frames;
                r_frame_idx   <= 8'd0;
                r_timeout_err <= 1'b0;
            end

            r_clr_cnt  <= (r_state == S_CLEAR) ? r_clr_cnt + 1'b1 : '0;
            r_wait_cnt <= (r_state == S_DRAIN) ? r_wait_cnt + 1'b1 : '0;

            if (r_state == S_CLEAR) begin
                r_pix_cnt <= '0;
            end else if (w_transfer) begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
            end

            if ((r_state == S_DRAIN) && bus.res_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= bus.res_data;
                r_out_frame <= r_frame_idx;
            end

            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end

            if (r_state == S_NEXT) begin
                r_frame_idx <= r_frame_idx + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.src_ready   = w_src_ready;
    assign bus.pipe_valid  = w_transfer;
    assign bus.pipe_data   = w_stream ? bus.src_data : '0;
    assign bus.pipe_res    = r_pipe_res;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_out_data;
    assign bus.out_frame   = r_out_frame;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_DONE);
    assign bus.timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: doc/cnn_frame_sequencer.md
Name: cnn_frame_sequencer

Overview:
- Frame-level controller in front of the conv/pooling + DNN inference chain.
- Accepts a start command with a frame count, clears the pipeline before each frame, and gates exactly ImageWidth*ImageWidth pixels per frame from the source into the conv pipeline.
- Waits for the DNN to signal completion and captures its class outputs, then repeats per frame.
- Adds a drain timeout so a stalled DNN cannot hang the system.

Parameters:
- BitSize, 32, pixel and result element width
- ImageWidth, 8, frame side length; pixels per frame P = ImageWidth*ImageWidth
- NumOutputs, 2, result elements per DNN output word
- ClearCycles, 2, cycles pipe_res is held high before each frame (>=1)
- DrainTimeout, 1024, max cycles in DRAIN waiting for res_done (>=1)

Ports:
- clk  in  1  clock
- res_n  in  1  synchronous reset, ACTIVE-HIGH (name kept per codebase; 1 = reset)
- start  in  1  begin a run; sampled only in IDLE
- num_frames  in  8  frames in the run; sampled with start
- src_valid  in  1  source pixel valid
- src_data  in  BitSize  source pixel
- src_ready  out  1  sequencer accepts pixel this cycle
- pipe_ready  in  1  conv pipeline can accept a pixel
- pipe_valid  out  1  pixel valid to conv pipeline
- pipe_data  out  BitSize  pixel to conv pipeline
- pipe_res  out  1  registered clear pulse to conv/DNN frame state
- res_valid  in  1  DNN output valid
- res_data  in  NumOutputs*BitSize  DNN output
- res_done  in  1  DNN finished current frame
- out_valid  out  1  captured result valid (1-cycle pulse)
- out_data  out  NumOutputs*BitSize  captured result
- out_frame  out  8  index of the frame that out_data belongs to
- busy  out  1  state != IDLE
- done  out  1  1-cycle pulse at end of run
- timeout_err  out  1  sticky; set on any drain timeout, cleared by start or reset

Behaviour:
- Reset (res_n=1 at posedge): state IDLE; all counters 0; all outputs 0. A reset asserted mid-run abandons the run immediately, with no done pulse.
- States: IDLE, CLEAR, STREAM, DRAIN, NEXT, DONE.
- IDLE: on start, latch num_frames and clear frame_idx and timeout_err.
  - If num_frames==0, go to DONE.
  - Otherwise go to CLEAR.
  - start in any other state is ignored.
- CLEAR: pipe_res=1 (registered, high exactly while in CLEAR) for ClearCycles cycles, then STREAM with pix_cnt=0.
- STREAM:
  - src_ready = pipe_ready (combinational); 0 in all other states.
  - pipe_valid = src_valid & src_ready; pipe_data = src_data (combinational pass-through, zero latency).
  - Each transfer increments pix_cnt.
  - On the transfer that makes pix_cnt==P, go to DRAIN next cycle; no pixel is accepted beyond P.
  - pix_cnt width is $clog2(P+1).
- DRAIN: wait_cnt increments each cycle.
  - On res_valid, register res_data into out_data, set out_frame=frame_idx, and pulse out_valid the next cycle. Multiple res_valid each produce a pulse.
  - On res_done, go to NEXT.
  - res_valid and res_done in the same cycle: the result is captured, then go to NEXT.
  - If wait_cnt reaches DrainTimeout with no res_done, set timeout_err and go to NEXT.
  - res_valid/res_done outside DRAIN are ignored.
- NEXT: frame_idx++.
  - If frame_idx+1 == latched num_frames, go to DONE.
  - Otherwise go to CLEAR.
- DONE: done=1 for one cycle, then IDLE. busy is 0 only in IDLE.
- frame_idx is 8-bit. num_frames=255 completes without wrap because the comparison is done before the increment.

Test Plan:
- Reset mid-STREAM (after 10 pixels), hold res_n=1 for 1 cycle -> next cycle busy=0, src_ready=0, pipe_res=0, done=0, out_valid=0. A new start with num_frames=1 runs normally.
- start with num_frames=2, ImageWidth=8, src_valid and pipe_ready held high, res_valid+res_done pulsed 5 cycles after each frame's last pixel with res_data=0x0000_0007_0000_0003:
  - pipe_res is high 2 cycles before each frame.
  - Exactly 64 pipe_valid per frame.
  - out_valid pulses twice with out_frame 0 then 1.
  - done pulses once; timeout_err=0.
- Backpressure: pipe_ready toggles 1/0 every cycle during STREAM -> src_ready mirrors pipe_ready; pipe_valid is never high while pipe_ready=0; still exactly 64 pixels forwarded.
- Timeout: DrainTimeout=16, res_done never asserted, num_frames=1 -> after 64 pixels, timeout_err=1 at the 16th DRAIN cycle and done pulses 2 cycles later; a subsequent start clears timeout_err.
- num_frames=0 -> busy=1 for exactly 1 cycle (DONE), done pulses, no pipe_res, src_ready stays 0.
- start asserted during STREAM, and res_done asserted during CLEAR -> both ignored; frame count and pixel count are unchanged.
